// File: rtl/piece_cell_scanner.sv
// Tetromino cell expander and collision checker: one cell per cycle, 1-cycle occupancy read port.
// Latency start->done 6 cycles (1 for invalid block); no backpressure, start only accepted while idle.
module piece_cell_scanner #(
    parameter int BOARD_W     = 10,
    parameter int BOARD_H     = 20,
    parameter int POS_W       = 5,
    parameter int IDX_W       = 8,
    parameter bit ALLOW_ABOVE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       block,
    input  logic [1:0]       status,
    input  logic [POS_W-1:0] pos_x,
    input  logic [POS_W-1:0] pos_y,
    output logic             busy,
    output logic             cell_valid,
    output logic [1:0]       cell_num,
    output logic [IDX_W-1:0] cell_idx,
    output logic             cell_oob,
    output logic             cell_hidden,
    output logic             rd_en,
    output logic [IDX_W-1:0] rd_addr,
    input  logic             rd_occ,
    output logic             done,
    output logic             fit,
    output logic             oob,
    output logic             err
);
    localparam int CW = POS_W + 2;
    localparam logic signed [CW-1:0] BW_S = CW'(BOARD_W);
    localparam logic signed [CW-1:0] BH_S = CW'(BOARD_H);
    localparam logic [IDX_W-1:0]     BW_I = IDX_W'(BOARD_W);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
    state_t state, state_nx;

    logic [1:0]       cnt;
    logic [2:0]       blk_q;
    logic [1:0]       rot_q;
    logic [POS_W-1:0] px_q, py_q;
    logic             rd_pend, col_q, oob_acc;

    logic signed [2:0]    bx, by, dx, dy;
    logic signed [CW-1:0] cx, cy;
    logic                 x_in, y_neg, y_hi, c_oob, c_hid, c_in;
    logic [IDX_W-1:0]     lin_idx;

    // Spawn-orientation offsets; cell 0 is always the centre.
    always_comb begin
        bx = 3'sd0;
        by = 3'sd0;
        case ({blk_q, cnt})
            5'b000_01: begin bx = -3'sd1; by =  3'sd1; end
            5'b000_10: begin bx = -3'sd1; by =  3'sd0; end
            5'b000_11: begin bx =  3'sd1; by =  3'sd0; end
            5'b001_01: begin bx =  3'sd1; by =  3'sd1; end
            5'b001_10: begin bx = -3'sd1; by =  3'sd0; end
            5'b001_11: begin bx =  3'sd1; by =  3'sd0; end
            5'b010_01: begin bx =  3'sd0; by =  3'sd1; end
            5'b010_10: begin bx =  3'sd1; by =  3'sd1; end
            5'b010_11: begin bx = -3'sd1; by =  3'sd0; end
            5'b011_01: begin bx =  3'sd0; by =  3'sd1; end
            5'b011_10: begin bx = -3'sd1; by =  3'sd0; end
            5'b011_11: begin bx =  3'sd1; by =  3'sd0; end
            5'b100_01: begin bx = -3'sd1; by =  3'sd1; end
            5'b100_10: begin bx =  3'sd0; by =  3'sd1; end
            5'b100_11: begin bx =  3'sd1; by =  3'sd0; end
            5'b101_01: begin bx = -3'sd1; by =  3'sd0; end
            5'b101_10: begin bx =  3'sd1; by =  3'sd0; end
            5'b101_11: begin bx =  3'sd2; by =  3'sd0; end
            5'b110_01: begin bx =  3'sd0; by =  3'sd1; end
            5'b110_10: begin bx =  3'sd1; by =  3'sd1; end
            5'b110_11: begin bx =  3'sd1; by =  3'sd0; end
            default:   begin bx =  3'sd0; by =  3'sd0; end
        endcase
    end

    always_comb begin
        dx = bx;
        dy = by;
        case (rot_q)
            2'd1:    begin dx =  by; dy = -bx; end
            2'd2:    begin dx = -bx; dy = -by; end
            2'd3:    begin dx = -by; dy =  bx; end
            default: begin dx =  bx; dy =  by; end
        endcase
    end

    // Signed coordinates wide enough that pos + offset can never wrap.
    always_comb begin
        cx      = $signed({2'b00, px_q}) + CW'(dx);
        cy      = $signed({2'b00, py_q}) + CW'(dy);
        x_in    = !cx[CW-1] && (cx < BW_S);
        y_neg   = cy[CW-1];
        y_hi    = !y_neg && (cy >= BH_S);
        c_oob   = !x_in || y_hi || (y_neg && !ALLOW_ABOVE);
        c_hid   = x_in && y_neg && ALLOW_ABOVE;
        c_in    = !c_oob && !c_hid;
        lin_idx = IDX_W'(cy) * BW_I + IDX_W'(cx);
    end

    assign busy        = (state == S_ISSUE) || (state == S_DRAIN);
    assign cell_valid  = (state == S_ISSUE);
    assign cell_num    = cell_valid ? cnt : 2'd0;
    assign cell_oob    = cell_valid && c_oob;
    assign cell_hidden = cell_valid && c_hid;
    assign rd_en       = cell_valid && c_in;
    assign cell_idx    = rd_en ? lin_idx : '0;
    assign rd_addr     = cell_idx;
    assign done        = (state == S_DONE);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = (block == 3'd7) ? S_DONE : S_ISSUE;
            S_ISSUE: if (cnt == 2'd3) state_nx = S_DRAIN;
            S_DRAIN: state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= 2'd0;
            blk_q   <= 3'd0;
            rot_q   <= 2'd0;
            px_q    <= '0;
            py_q    <= '0;
            rd_pend <= 1'b0;
            col_q   <= 1'b0;
            oob_acc <= 1'b0;
            fit     <= 1'b0;
            oob     <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nx;
            rd_pend <= rd_en;
            case (state)
                S_IDLE: if (start) begin
                    blk_q   <= block;
                    rot_q   <= status;
                    px_q    <= pos_x;
                    py_q    <= pos_y;
                    cnt     <= 2'd0;
                    col_q   <= 1'b0;
                    oob_acc <= 1'b0;
                    fit     <= 1'b0;
                    oob     <= 1'b0;
                    err     <= (block == 3'd7);
                end
                S_ISSUE: begin
                    cnt <= cnt + 2'd1;
                    if (c_oob) begin
                        oob_acc <= 1'b1;
                        col_q   <= 1'b1;
                    end
                    if (rd_pend && rd_occ) col_q <= 1'b1;
                end
                // Verdict folds in the final read, which returns during DRAIN.
                S_DRAIN: begin
                    fit <= !(col_q || (rd_pend && rd_occ)) && !err;
                    oob <= oob_acc;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_piece_cell_scanner.sv
// Scoreboard bench for piece_cell_scanner: ALLOW_ABOVE=1 instance fully checked, ALLOW_ABOVE=0 instance checked on verdicts.
module tb_piece_cell_scanner;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] block = 3'd0;
    logic [1:0] status = 2'd0;
    logic [4:0] pos_x = 5'd0, pos_y = 5'd0;

    logic       busy, cell_valid, cell_oob, cell_hidden, rd_en, rd_occ, done, fit, oob, err;
    logic [1:0] cell_num;
    logic [7:0] cell_idx, rd_addr;
    logic       busy_b, cell_valid_b, cell_oob_b, cell_hidden_b, rd_en_b, rd_occ_b, done_b, fit_b, oob_b, err_b;
    logic [1:0] cell_num_b;
    logic [7:0] cell_idx_b, rd_addr_b;

    logic occ [0:255];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    typedef struct packed {
        logic [1:0] num;
        logic [7:0] idx;
        logic       oob;
        logic       hid;
        logic       rd;
    } cell_t;
    typedef struct packed {
        logic [2:0] res;
        logic [2:0] res_b;
        int         dcyc;
    } res_t;

    cell_t cq[$];
    res_t  rq[$];
    cell_t ce;
    res_t  re;

    piece_cell_scanner #(.BOARD_W(10), .BOARD_H(20), .POS_W(5), .IDX_W(8), .ALLOW_ABOVE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .block(block), .status(status),
        .pos_x(pos_x), .pos_y(pos_y), .busy(busy), .cell_valid(cell_valid), .cell_num(cell_num),
        .cell_idx(cell_idx), .cell_oob(cell_oob), .cell_hidden(cell_hidden), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_occ(rd_occ), .done(done), .fit(fit), .oob(oob), .err(err));

    piece_cell_scanner #(.BOARD_W(10), .BOARD_H(20), .POS_W(5), .IDX_W(8), .ALLOW_ABOVE(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .block(block), .status(status),
        .pos_x(pos_x), .pos_y(pos_y), .busy(busy_b), .cell_valid(cell_valid_b), .cell_num(cell_num_b),
        .cell_idx(cell_idx_b), .cell_oob(cell_oob_b), .cell_hidden(cell_hidden_b), .rd_en(rd_en_b),
        .rd_addr(rd_addr_b), .rd_occ(rd_occ_b), .done(done_b), .fit(fit_b), .oob(oob_b), .err(err_b));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rd_occ   <= rd_en && occ[rd_addr];
        rd_occ_b <= rd_en_b && occ[rd_addr_b];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a cell or a verdict.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cell_valid) begin
                chk("busy_in_issue", 32'(busy), 32'd1);
                if (cq.size() == 0) begin
                    chk("cell_unexpected", 32'd1, 32'd0);
                end else begin
                    ce = cq.pop_front();
                    chk("cell", 32'({cell_num, cell_idx, cell_oob, cell_hidden, rd_en}), 32'(ce));
                    if (ce.rd) chk("rd_addr", 32'(rd_addr), 32'(ce.idx));
                end
            end
            if (done) begin
                if (rq.size() == 0) begin
                    chk("done_unexpected", 32'd1, 32'd0);
                end else begin
                    re = rq.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(re.dcyc));
                    chk("busy_at_done", 32'(busy), 32'd0);
                    chk("verdict", 32'({fit, oob, err}), 32'(re.res));
                    chk("done_b", 32'(done_b), 32'd1);
                    chk("verdict_b", 32'({fit_b, oob_b, err_b}), 32'(re.res_b));
                end
            end else if (done_b) begin
                chk("done_b_unexpected", 32'd1, 32'd0);
            end
        end
    end

    // idxs packs cell3..cell0 as {i3,i2,i1,i0}; res = {fit,oob,err}.
    task automatic run(input logic [2:0] b, input logic [1:0] s, input logic [4:0] px,
                       input logic [4:0] py, input logic [31:0] idxs, input logic [3:0] om,
                       input logic [3:0] hm, input logic [2:0] r, input logic [2:0] rb,
                       input bit poke);
        cell_t c;
        res_t  e;
        @(posedge clk); #1;
        block = b; status = s; pos_x = px; pos_y = py; start = 1'b1;
        if (b != 3'd7) begin
            for (int i = 0; i < 4; i++) begin
                c.num = 2'(i);
                c.idx = idxs[8*i +: 8];
                c.oob = om[i];
                c.hid = hm[i];
                c.rd  = !(om[i] || hm[i]);
                cq.push_back(c);
            end
        end
        e.res = r; e.res_b = rb; e.dcyc = cyc + ((b == 3'd7) ? 1 : 6);
        rq.push_back(e);
        @(posedge clk); #1;
        start = 1'b0; block = 3'd6; status = ~s; pos_x = ~px; pos_y = ~py;
        if (poke) begin
            @(posedge clk); #1; start = 1'b1;
            @(posedge clk); #1; start = 1'b0;
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("done_seen", 32'(done), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) occ[i] = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ctrl", 32'({busy, cell_valid, rd_en, done, cell_oob, cell_hidden}), 32'd0);
        chk("rst_verdict", 32'({fit, oob, err, fit_b, oob_b, err_b}), 32'd0);
        chk("rst_idx", 32'({cell_idx, rd_addr, cell_num}), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        run(3'd3, 2'd0, 5'd4, 5'd0,  {8'd5,   8'd3,   8'd14,  8'd4},   4'b0000, 4'b0000, 3'b100, 3'b100, 1'b1);
        run(3'd5, 2'd1, 5'd0, 5'd5,  {8'd30,  8'd40,  8'd60,  8'd50},  4'b0000, 4'b0000, 3'b100, 3'b100, 1'b0);
        occ[14] = 1'b1;
        run(3'd3, 2'd0, 5'd4, 5'd0,  {8'd5,   8'd3,   8'd14,  8'd4},   4'b0000, 4'b0000, 3'b000, 3'b000, 1'b0);
        occ[14] = 1'b0;
        run(3'd0, 2'd0, 5'd0, 5'd3,  {8'd31,  8'd0,   8'd0,   8'd30},  4'b0110, 4'b0000, 3'b010, 3'b010, 1'b0);
        run(3'd5, 2'd1, 5'd3, 5'd1,  {8'd0,   8'd3,   8'd23,  8'd13},  4'b0000, 4'b1000, 3'b100, 3'b010, 1'b0);
        run(3'd7, 2'd0, 5'd4, 5'd4,  32'd0,                            4'b0000, 4'b0000, 3'b001, 3'b001, 1'b0);
        run(3'd2, 2'd2, 5'd9, 5'd19, {8'd0,   8'd188, 8'd189, 8'd199}, 4'b1000, 4'b0000, 3'b010, 3'b010, 1'b0);
        occ[115] = 1'b1;
        run(3'd4, 2'd3, 5'd5, 5'd10, {8'd115, 8'd104, 8'd94,  8'd105}, 4'b0000, 4'b0000, 3'b000, 3'b000, 1'b0);
        occ[115] = 1'b0;
        run(3'd4, 2'd3, 5'd5, 5'd10, {8'd115, 8'd104, 8'd94,  8'd105}, 4'b0000, 4'b0000, 3'b100, 3'b100, 1'b0);
        run(3'd0, 2'd0, 5'd4, 5'd19, {8'd195, 8'd193, 8'd0,   8'd194}, 4'b0010, 4'b0000, 3'b010, 3'b010, 1'b0);
        run(3'd1, 2'd1, 5'd1, 5'd18, {8'd171, 8'd191, 8'd172, 8'd181}, 4'b0000, 4'b0000, 3'b100, 3'b100, 1'b0);
        run(3'd6, 2'd0, 5'd8, 5'd0,  {8'd9,   8'd19,  8'd18,  8'd8},   4'b0000, 4'b0000, 3'b100, 3'b100, 1'b0);

        // Abort mid-scan: reset asserted during cycle 3 after start.
        @(posedge clk); #1;
        block = 3'd3; status = 2'd0; pos_x = 5'd4; pos_y = 5'd0; start = 1'b1;
        cq.push_back('{num: 2'd0, idx: 8'd4,  oob: 1'b0, hid: 1'b0, rd: 1'b1});
        cq.push_back('{num: 2'd1, idx: 8'd14, oob: 1'b0, hid: 1'b0, rd: 1'b1});
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        chk("abort_ctrl", 32'({busy, cell_valid, rd_en, done, cell_oob, cell_hidden}), 32'd0);
        chk("abort_verdict", 32'({fit, oob, err, fit_b, oob_b, err_b}), 32'd0);
        chk("abort_cells_seen", 32'(cq.size()), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        run(3'd3, 2'd0, 5'd4, 5'd0,  {8'd5,   8'd3,   8'd14,  8'd4},   4'b0000, 4'b0000, 3'b100, 3'b100, 1'b0);

        repeat (3) @(negedge clk);
        chk("cell_queue_drained", 32'(cq.size()), 32'd0);
        chk("result_queue_drained", 32'(rq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
